calc_cmd_sequencer: RTL and testbench
=====================================

// Module: calc_cmd_sequencer
// PURPOSE
//  Command-side driver for the accumulator calculator. It queues (op, operand) commands from
//  a valid/ready source and replays each one onto the calculator's en/in/op input lines as a
//  clean en strobe. The calculator acts only on a rising edge of en, so every strobe is
//  followed by an en-low gap. A shadow accumulator mirrors the calculator's expected result.
// PARAMETERS
//  FIFO_DEPTH     4  command queue entries (power of 2, >=2)
//  EN_HIGH_CYCLES 1  cycles en_out held high per command (>=1)
//  EN_LOW_CYCLES  1  cycles en_out held low after strobe (>=1, guarantees a new rising edge)
// PORTS
//  clock         in   1  single clock, all logic on posedge
//  reset         in   1  synchronous, active-high
//  cmd_valid     in   1  command offered
//  cmd_ready     out  1  queue not full
//  cmd_op        in   2  00 add, 01 sub, 10 xor, 11 shift-left
//  cmd_operand   in   3  unsigned operand
//  pause         in   1  1 = do not start a new command (the current command completes)
//  en_out        out  1  to calculator en
//  in_out        out  3  to calculator operand
//  op_out        out  2  to calculator op select
//  busy          out  1  state != IDLE or queue non-empty
//  issued_count  out  8  commands strobed since reset, wraps 255->0
//  expected      out  8  shadow accumulator value
// BEHAVIOUR
//  - Reset: queue emptied, state IDLE, en_out/in_out/op_out/issued_count/expected = 0, cmd_ready=1.
//  - Push on cmd_valid&&cmd_ready. When full, cmd_ready=0 even if a pop occurs the same cycle
//    (no bypass). Pushes while cmd_ready=0 are ignored.
//  - FSM IDLE -> SETUP -> STROBE -> GAP -> IDLE. All outputs are registered.
//    IDLE:   if queue non-empty and !pause, pop the head; next state is SETUP.
//    SETUP:  1 cycle; in_out/op_out show the popped command; en_out=0.
//    STROBE: EN_HIGH_CYCLES cycles; en_out=1; in_out/op_out held stable.
//            On entry: issued_count++ and expected updated.
//    GAP:    EN_LOW_CYCLES cycles; en_out=0; in_out/op_out held. Then IDLE.
//  - Command period = 2 + EN_HIGH_CYCLES + EN_LOW_CYCLES cycles. The first en_out=1 appears
//    3 cycles after a push into an empty queue when not paused.
//  - Shadow arithmetic is mod 2^8, with the operand zero-extended:
//    add: acc+opd; sub: acc-opd (0-1=255); xor: acc^opd; shl: acc<<opd (bits shifted out are lost).
//  - pause is sampled only in IDLE and never truncates a strobe or a gap.
//  - Reset mid-operation: en_out=0 at the next edge and the in-flight command is discarded.
//    The calculator must be reset in the same cycle to stay consistent with expected.
// CONFIGURATION
//  SHADOW_CHECK_EN defined:
//    - Adds port result_in (in, 8; the calculator output) and port mismatch (out, 1).
//    - On the last GAP cycle, if result_in != expected then mismatch is set.
//    - mismatch is sticky; only reset clears it.
//  SHADOW_CHECK_EN undefined: result_in and mismatch are absent, with no compare logic.
// STRUCTURE
//  - Package calc_pkg: OP_ADD/OP_SUB/OP_XOR/OP_SHL localparams, calc_cmd_t {op[1:0], operand[2:0]},
//    FSM state enum, io_in bit-position constants (EN_BIT=2, IN_LSB=3, OP_LSB=6).
//  - Sub-module calc_cmd_fifo: synchronous FIFO of calc_cmd_t with full/empty flags.
//  - Top level: FSM, cycle counter, shadow accumulator, optional checker.
// TESTING
//  1. Reset, push ADD 5 -> en_out high for exactly 1 cycle, 3 cycles after the push, with
//     in_out=5, op_out=00; expected=5; issued_count=1.
//  2. Push ADD 7, SUB 2, XOR 3, SHL 1 -> expected steps 7,5,6,12; 4 separate en pulses,
//     each preceded and followed by en_out=0.
//  3. pause=1, push 5 cmds -> cmd_ready=0 after the 4th, the 5th is dropped; release pause
//     -> exactly 4 strobes, then busy=0.
//  4. After reset, SUB 1 -> expected=255. Then SHL 7 on expected=3 -> 128.
//  5. Assert reset during STROBE -> en_out=0 next cycle, cmd_ready=1, expected=0, no further strobes.
//  6. SHADOW_CHECK_EN: ADD 4 with result_in tied to 3 -> mismatch=1 on the last GAP cycle;
//     it stays 1 through later matching cmds until reset.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the accumulator-calculator command sequencer:
// opcodes, command record, FSM states, calculator io_in bit positions and the shadow ALU.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

  // Bit positions of en/in/op on the calculator's packed io_in bus.
  localparam int EN_BIT = 2;
  localparam int IN_LSB = 3;
  localparam int OP_LSB = 6;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] operand;
  } calc_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_GAP
  } state_e;

  function automatic logic [7:0] calc_apply(input logic [7:0] acc, input calc_cmd_t cmd);
    logic [7:0] opd;
    logic [7:0] res;
    opd = {5'b0, cmd.operand};
    case (cmd.op)
      OP_ADD:  res = acc + opd;
      OP_SUB:  res = acc - opd;
      OP_XOR:  res = acc ^ opd;
      default: res = acc << cmd.operand;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calc_cmd_sequencer_if.sv
// Command valid/ready channel between a command source and the sequencer.
interface calc_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_operand;

  modport master (output cmd_valid, cmd_op, cmd_operand, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_operand, output cmd_ready);
endinterface

// File: rtl/calc_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty; pushes while full and pops while
// empty are ignored, and there is no push-through-pop bypass when full.
module calc_cmd_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  calc_cmd_t push_dat_i,
  input  logic      pop_i,
  output calc_cmd_t pop_dat_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  calc_cmd_t     mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Replays queued commands onto the calculator as SETUP/STROBE/GAP en pulses and tracks a
// shadow accumulator. SHADOW_CHECK_EN adds result_in and a sticky mismatch flag.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int EN_HIGH_CYCLES = 1,
  parameter int EN_LOW_CYCLES  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  calc_cmd_sequencer_if.slave  cmd,
  input  logic                 pause,
  output logic                 en_out,
  output logic [2:0]           in_out,
  output logic [1:0]           op_out,
  output logic                 busy,
  output logic [7:0]           issued_count,
  output logic [7:0]           expected
`ifdef SHADOW_CHECK_EN
  ,
  input  logic [7:0]           result_in,
  output logic                 mismatch
`endif
);

  localparam logic [7:0] HI_LAST = 8'(EN_HIGH_CYCLES - 1);
  localparam logic [7:0] LO_LAST = 8'(EN_LOW_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       en_q, en_d;
  logic [2:0] in_q, in_d;
  logic [1:0] op_q, op_d;
  logic [7:0] issued_q, issued_d;
  logic [7:0] acc_q, acc_d;
  logic       pop;
  logic       fifo_full, fifo_empty;
  calc_cmd_t  head;
  calc_cmd_t  cur;

  calc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (cmd.cmd_valid),
    .push_dat_i ({cmd.cmd_op, cmd.cmd_operand}),
    .pop_i      (pop),
    .pop_dat_o  (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign cmd.cmd_ready = !fifo_full;
  assign cur           = {op_q, in_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    in_d     = in_q;
    op_d     = op_q;
    issued_d = issued_q;
    acc_d    = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !pause) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
          in_d    = head.operand;
          op_d    = head.op;
        end
      end
      ST_SETUP: begin
        state_d  = ST_STROBE;
        cnt_d    = '0;
        issued_d = issued_q + 8'd1;
        acc_d    = calc_apply(acc_q, cur);
      end
      ST_STROBE: begin
        if (cnt_q == HI_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == LO_LAST) state_d = ST_IDLE;
        else                  cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // en is registered from the next state so it lines up exactly with STROBE.
    en_d = (state_d == ST_STROBE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      in_q     <= '0;
      op_q     <= '0;
      issued_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      in_q     <= in_d;
      op_q     <= op_d;
      issued_q <= issued_d;
      acc_q    <= acc_d;
    end
  end

  assign en_out       = en_q;
  assign in_out       = in_q;
  assign op_out       = op_q;
  assign issued_count = issued_q;
  assign expected     = acc_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;

`ifdef SHADOW_CHECK_EN
  logic mismatch_q, mismatch_d;
  logic last_gap;

  // The calculator has settled by the final gap cycle, so compare there once per command.
  assign last_gap   = (state_q == ST_GAP) && (cnt_q == LO_LAST);
  assign mismatch_d = mismatch_q || (last_gap && (result_in != acc_q));

  always_ff @(posedge clock) begin
    if (reset) mismatch_q <= 1'b0;
    else       mismatch_q <= mismatch_d;
  end

  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Scoreboard bench for calc_cmd_sequencer: commands are modelled at push time and checked
// against each rising edge of en_out.
module tb_calc_cmd_sequencer;
  import calc_pkg::*;

  typedef struct {
    logic [2:0] opd;
    logic [1:0] op;
    logic [7:0] acc;
    logic [7:0] cnt;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       pause;
  logic       en_out;
  logic [2:0] in_out;
  logic [1:0] op_out;
  logic       busy;
  logic [7:0] issued_count;
  logic [7:0] expected;
`ifdef SHADOW_CHECK_EN
  logic [7:0] result_in;
  logic       mismatch;
`endif

  calc_cmd_sequencer_if cif ();

  calc_cmd_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .cmd          (cif),
    .pause        (pause),
    .en_out       (en_out),
    .in_out       (in_out),
    .op_out       (op_out),
    .busy         (busy),
    .issued_count (issued_count),
    .expected     (expected)
`ifdef SHADOW_CHECK_EN
    ,
    .result_in    (result_in),
    .mismatch     (mismatch)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         strobes = 0;
  logic [7:0] m_acc = 8'd0;
  logic [7:0] m_cnt = 8'd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] acc, input logic [1:0] op,
                                       input logic [2:0] opd);
    int a;
    a = int'(acc);
    case (op)
      2'd0:    a = a + int'(opd);
      2'd1:    a = a + 256 - int'(opd);
      2'd2:    a = a ^ int'(opd);
      default: a = a * (1 << opd);
    endcase
    return 8'(a % 256);
  endfunction

  // Monitor: each en rising edge consumes one scoreboard entry; each pulse must be 1 cycle.
  initial begin
    logic en_prev;
    int   hi_len;
    exp_t e;
    en_prev = 1'b0;
    hi_len  = 0;
    forever begin
      @(negedge clock);
      if (en_out && !en_prev) begin
        strobes++;
        hi_len = 1;
        if (sb.size() == 0) begin
          chk("strobe_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("in_out", in_out, e.opd);
          chk("op_out", op_out, e.op);
          chk("expected", expected, e.acc);
          chk("issued_count", issued_count, e.cnt);
        end
      end else if (en_out) begin
        hi_len++;
      end else if (en_prev) begin
        chk("en_width", hi_len, 1);
      end
      en_prev = en_out;
    end
  end

  task automatic rst_dut();
    @(negedge clock);
    #1;
    reset = 1'b1;
    sb.delete();
    m_acc = 8'd0;
    m_cnt = 8'd0;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [2:0] opd, output logic accepted);
    @(negedge clock);
    #1;
    cif.cmd_valid   = 1'b1;
    cif.cmd_op      = op;
    cif.cmd_operand = opd;
    accepted = cif.cmd_ready;
    if (accepted) begin
      m_acc = model(m_acc, op, opd);
      m_cnt = m_cnt + 8'd1;
      sb.push_back('{opd, op, m_acc, m_cnt});
    end
    @(posedge clock);
    #1;
    cif.cmd_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [1:0] op, input logic [2:0] opd);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) push_cmd(op, opd, acc);
    chk("push_timeout", acc, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (!busy) break;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    logic acc;
    int   s0;
    reset = 1'b0;
    pause = 1'b0;
    cif.cmd_valid   = 1'b0;
    cif.cmd_op      = 2'd0;
    cif.cmd_operand = 3'd0;
`ifdef SHADOW_CHECK_EN
    result_in = 8'd0;
`endif

    // Reset state
    rst_dut();
    chk("rst_en", en_out, 0);
    chk("rst_in", in_out, 0);
    chk("rst_op", op_out, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_expected", expected, 0);
    chk("rst_ready", cif.cmd_ready, 1);
    chk("rst_busy", busy, 0);

    // First command latency and single-cycle strobe
    push_cmd(OP_ADD, 3'd5, acc);
    chk("t1_accept", acc, 1);
    @(posedge clock); #1;
    chk("t1_en_setup", en_out, 0);
    chk("t1_in_setup", in_out, 5);
    @(posedge clock); #1;
    chk("t1_en_strobe", en_out, 1);
    chk("t1_expected", expected, 5);
    chk("t1_issued", issued_count, 1);
    @(posedge clock); #1;
    chk("t1_en_gap", en_out, 0);
    wait_idle("t1_idle");

    // Mixed ops from zero: 7, 5, 6, 12
    rst_dut();
    s0 = strobes;
    push_wait(OP_ADD, 3'd7);
    push_wait(OP_SUB, 3'd2);
    push_wait(OP_XOR, 3'd3);
    push_wait(OP_SHL, 3'd1);
    wait_idle("t2_idle");
    chk("t2_strobes", strobes - s0, 4);
    chk("t2_final", expected, 12);

    // Pause fills the queue; the fifth push is dropped
    rst_dut();
    pause = 1'b1;
    s0 = strobes;
    for (int i = 0; i < 4; i++) begin
      push_cmd(OP_ADD, 3'(i + 1), acc);
      chk("t3_accept", acc, 1);
    end
    chk("t3_ready_full", cif.cmd_ready, 0);
    push_cmd(OP_ADD, 3'd7, acc);
    chk("t3_drop", acc, 0);
    repeat (5) @(posedge clock);
    #1;
    chk("t3_paused_busy", busy, 1);
    chk("t3_paused_strobes", strobes - s0, 0);
    pause = 1'b0;
    wait_idle("t3_idle");
    chk("t3_strobes", strobes - s0, 4);
    chk("t3_final", expected, 10);

    // Subtract underflow and shift overflow
    rst_dut();
    push_wait(OP_SUB, 3'd1);
    wait_idle("t4a_idle");
    chk("t4_sub_wrap", expected, 255);
    push_wait(OP_ADD, 3'd4);
    push_wait(OP_SHL, 3'd7);
    wait_idle("t4b_idle");
    chk("t4_shl", expected, 128);

    // Reset during a strobe discards the in-flight and queued commands
    rst_dut();
    push_wait(OP_ADD, 3'd6);
    push_wait(OP_ADD, 3'd1);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(posedge clock); #1;
      acc = en_out;
    end
    chk("t5_saw_strobe", acc, 1);
    rst_dut();
    chk("t5_en", en_out, 0);
    chk("t5_ready", cif.cmd_ready, 1);
    chk("t5_expected", expected, 0);
    chk("t5_issued", issued_count, 0);
    s0 = strobes;
    repeat (12) @(posedge clock);
    #1;
    chk("t5_no_strobes", strobes - s0, 0);
    chk("t5_busy", busy, 0);

`ifdef SHADOW_CHECK_EN
    // Sticky mismatch flag
    rst_dut();
    chk("t6_rst_mismatch", mismatch, 0);
    result_in = 8'd3;
    push_wait(OP_ADD, 3'd4);
    wait_idle("t6a_idle");
    chk("t6_mismatch_set", mismatch, 1);
    result_in = 8'd8;
    push_wait(OP_ADD, 3'd4);
    wait_idle("t6b_idle");
    chk("t6_expected", expected, 8);
    chk("t6_mismatch_sticky", mismatch, 1);
    rst_dut();
    chk("t6_mismatch_clr", mismatch, 0);
`endif

    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
